sync_up_counter: RTL and testbench
==================================

// Module: sync_up_counter
// PURPOSE
//  Synchronous modulo-N binary up counter built from clock-enabled JK flip-flops.
//  It is the counting-up counterpart of the team's ripple down counter.
//  All flops share one clock, so there is no ripple skew.
//  Cascadable through co/ci to build wider BCD or modulo displays (LED/7-seg labs).
// PARAMETERS
//  WIDTH    4   counter width in bits (1..16)
//  MODULUS  16  count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH
// PORTS
//  clk    in   1      single clock, all state updates on posedge
//  rst_n  in   1      synchronous reset, active-low
//  ci     in   1      count enable / carry-in from lower stage
//  load   in   1      synchronous parallel load
//  din    in   WIDTH  load value
//  clr    in   1      synchronous clear of q and ovf (not a reset)
//  q      out  WIDTH  current count (registered)
//  tc     out  1      terminal count: q == MODULUS-1 (registered-derived, glitch-free)
//  co     out  1      carry-out = ci & tc (combinational, for cascading)
//  ovf    out  1      sticky: set on any wrap MODULUS-1 -> 0
// BEHAVIOUR
//  - Interface: one clock clk; reset rst_n is synchronous and active-low.
//  - Reset (rst_n==0 at posedge): q=0, tc=0 (or 1 if MODULUS==1, not allowed), ovf=0.
//    co follows ci&tc, so co=0 after reset.
//  - Priority per posedge: rst_n > clr > load > ci > hold.
//  - clr: q<=0, ovf<=0.
//  - load:
//    - q<=din if din<MODULUS, else q<=0.
//    - ovf unchanged.
//    - load with ci=1 loads only; no increment that cycle.
//  - ci=1, no load/clr:
//    - if q==MODULUS-1: q<=0 and ovf<=1.
//    - otherwise: q<=q+1.
//  - ci=0: q and ovf hold.
//  - Latency: q changes one cycle after the qualifying edge.
//    - tc is valid in the same cycle as q.
//    - co is combinational from ci and tc; there is no flop on co.
//  - Width rule: the increment is computed in WIDTH+1 bits and compared against MODULUS-1.
//    q never holds a value >= MODULUS after reset, clr or load.
//  - Illegal state (q>=MODULUS, only reachable via X/upset): the next ci or load forces a legal value.
//    - ci=1 from an illegal state gives q<=0 with no ovf.
//  - Reset mid-count: rst_n low overrides everything that cycle; counting resumes from 0 on the first ci after release.
//  - Simultaneous clr+load+ci: clr wins, q=0, ovf=0.
// STRUCTURE
//  - Shared package cnt_pkg:
//    - localparam helper function clog2.
//    - Typedef/defines for the JK encoding: HOLD=2'b00, RESET=2'b01, SET=2'b10, TOGGLE=2'b11.
//  - Sub-module jk_ff_sync, instantiated WIDTH times (generate loop):
//    - Ports: clk, rst_n, j, k, q, qn.
//    - Synchronous active-low reset to q=0, qn=1.
//  - Top computes next-state (q_nxt) combinationally.
//    - Each bit is driven with j=q_nxt[i]&~q[i] and k=~q_nxt[i]&q[i].
//  - ovf is a plain flop in the top. tc and co are combinational from q and ci.
// TESTING
//  - Reset: rst_n=0 for 2 cycles with ci=1 -> q=0, ovf=0, co=0. Release -> q=1 after the first edge.
//  - Default params, ci=1 for 17 cycles from 0:
//    - q steps 0..15 then 0.
//    - tc=1 only at q=15; co=1 only at q=15.
//    - ovf=1 from the wrap on and stays 1.
//  - MODULUS=10, load din=7 then ci=1 for 3 cycles -> q=7,8,9,0 and ovf=1.
//    - load din=12 -> q=0.
//  - Same cycle load=1, ci=1, din=5 -> q=5 (no increment).
//    - Same cycle clr=1, load=1 -> q=0, ovf=0.
//  - Two instances (MODULUS=10) cascaded via co->ci, 100 ci pulses -> display reads 00..99.
//    - Upper stage co=1 exactly at 99.
//  - Mid-count rst_n=0 at q=6 with ci=1 -> q=0 next edge. ci=0 holds q for 5 cycles.

Source files
------------

// File: rtl/cnt_pkg.sv
// Shared definitions for the synchronous counter family: JK action encoding
// and an elaboration-time log2 helper.
package cnt_pkg;

    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_op_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/jk_ff_sync.sv
// Clock-enabled JK flip-flop with synchronous active-low reset; q and qn are
// both held in flops so they stay complementary without a combinational inverter.
module jk_ff_sync
    import cnt_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qn
);

    logic   q_r;
    logic   qn_r;
    jk_op_e op_s;

    // Map the J/K pins onto the named flop action
    always_comb begin
        op_s = jk_op_e'({j, k});
    end

    // JK state update with synchronous reset to q=0, qn=1
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_r  <= 1'b0;
            qn_r <= 1'b1;
        end else begin
            case (op_s)
                JK_HOLD: begin
                    q_r  <= q_r;
                    qn_r <= qn_r;
                end
                JK_RESET: begin
                    q_r  <= 1'b0;
                    qn_r <= 1'b1;
                end
                JK_SET: begin
                    q_r  <= 1'b1;
                    qn_r <= 1'b0;
                end
                JK_TOGGLE: begin
                    q_r  <= qn_r;
                    qn_r <= q_r;
                end
                default: begin
                    q_r  <= q_r;
                    qn_r <= qn_r;
                end
            endcase
        end
    end

    assign q  = q_r;
    assign qn = qn_r;

endmodule

// File: rtl/sync_up_counter_chk.sv
// Property checker for sync_up_counter: count stays in range and the
// terminal-count / carry outputs agree with the count.
module sync_up_counter_chk #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input logic             clk,
    input logic             rst_n,
    input logic             ci,
    input logic [WIDTH-1:0] q,
    input logic             tc,
    input logic             co
);

    localparam logic [WIDTH:0] MOD_C = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH:0] TOP_C = (WIDTH + 1)'(MODULUS - 1);

    a_q_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        ({1'b0, q} < MOD_C));

    a_tc_matches: assert property (@(posedge clk) disable iff (!rst_n)
        (tc == ({1'b0, q} == TOP_C)));

    a_co_matches: assert property (@(posedge clk) disable iff (!rst_n)
        (co == (ci & tc)));

endmodule

// File: rtl/sync_up_counter.sv
// Synchronous modulo-MODULUS up counter built from JK flops sharing one clock;
// co/ci let several stages cascade into a wider decimal or modulo display.
module sync_up_counter
    import cnt_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ci,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             co,
    output logic             ovf
);

    localparam logic [WIDTH:0] MOD_C = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH:0] ONE_C = (WIDTH + 1)'(1);

    logic [WIDTH-1:0] q_s;
    logic [WIDTH-1:0] qn_s;
    logic [WIDTH-1:0] q_nxt_s;
    logic [WIDTH-1:0] j_s;
    logic [WIDTH-1:0] k_s;
    logic [WIDTH:0]   q_ext_s;
    logic [WIDTH:0]   q_inc_s;
    logic             at_top_s;
    logic             legal_s;
    logic             din_ok_s;
    logic             ovf_nxt_s;
    logic             ovf_r;

    // Range decode done one bit wider so MODULUS == 2**WIDTH cannot overflow
    always_comb begin
        q_ext_s  = {1'b0, q_s};
        q_inc_s  = q_ext_s + ONE_C;
        at_top_s = (q_inc_s == MOD_C);
        legal_s  = (q_ext_s < MOD_C);
        din_ok_s = ({1'b0, din} < MOD_C);
    end

    // Next count and overflow flag, priority clr > load > ci > hold
    always_comb begin
        q_nxt_s   = q_s;
        ovf_nxt_s = ovf_r;
        if (clr) begin
            q_nxt_s   = {WIDTH{1'b0}};
            ovf_nxt_s = 1'b0;
        end else if (load) begin
            if (din_ok_s) begin
                q_nxt_s = din;
            end else begin
                q_nxt_s = {WIDTH{1'b0}};
            end
        end else if (ci) begin
            // An out-of-range count is recovered to zero without flagging a wrap
            if (!legal_s) begin
                q_nxt_s = {WIDTH{1'b0}};
            end else if (at_top_s) begin
                q_nxt_s   = {WIDTH{1'b0}};
                ovf_nxt_s = 1'b1;
            end else begin
                q_nxt_s = q_inc_s[WIDTH-1:0];
            end
        end else begin
            q_nxt_s   = q_s;
            ovf_nxt_s = ovf_r;
        end
    end

    // Sticky wrap flag, cleared by reset or clr
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_nxt_s;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        // Set only bits that must rise, reset only bits that must fall
        assign j_s[i] = q_nxt_s[i] & qn_s[i];
        assign k_s[i] = ~q_nxt_s[i] & q_s[i];

        jk_ff_sync u_jk (
            .clk   (clk),
            .rst_n (rst_n),
            .j     (j_s[i]),
            .k     (k_s[i]),
            .q     (q_s[i]),
            .qn    (qn_s[i])
        );
    end

    assign q   = q_s;
    assign tc  = at_top_s;
    assign co  = ci & at_top_s;
    assign ovf = ovf_r;

endmodule

// File: tb/tb_sync_up_counter.sv
// Self-checking bench for sync_up_counter: vector table, counting/cascade
// sequences and randomized traffic against an arithmetic reference model.
module tb_sync_up_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // modulo-10 instance
    logic       a_rst_n, a_ci, a_load, a_clr;
    logic [3:0] a_din;
    logic [3:0] a_q;
    logic       a_tc, a_co, a_ovf;

    // default modulo-16 instance
    logic       b_rst_n, b_ci, b_load, b_clr;
    logic [3:0] b_din;
    logic [3:0] b_q;
    logic       b_tc, b_co, b_ovf;

    // two-digit decimal cascade
    logic       c_rst_n, c_ci;
    logic [3:0] lo_q, hi_q;
    logic       lo_tc, lo_co, lo_ovf, hi_tc, hi_co, hi_ovf;

    sync_up_counter #(.WIDTH(4), .MODULUS(10)) dut_a (
        .clk(clk), .rst_n(a_rst_n), .ci(a_ci), .load(a_load), .din(a_din),
        .clr(a_clr), .q(a_q), .tc(a_tc), .co(a_co), .ovf(a_ovf));

    sync_up_counter dut_b (
        .clk(clk), .rst_n(b_rst_n), .ci(b_ci), .load(b_load), .din(b_din),
        .clr(b_clr), .q(b_q), .tc(b_tc), .co(b_co), .ovf(b_ovf));

    sync_up_counter #(.WIDTH(4), .MODULUS(10)) dut_lo (
        .clk(clk), .rst_n(c_rst_n), .ci(c_ci), .load(1'b0), .din(4'd0),
        .clr(1'b0), .q(lo_q), .tc(lo_tc), .co(lo_co), .ovf(lo_ovf));

    sync_up_counter #(.WIDTH(4), .MODULUS(10)) dut_hi (
        .clk(clk), .rst_n(c_rst_n), .ci(lo_co), .load(1'b0), .din(4'd0),
        .clr(1'b0), .q(hi_q), .tc(hi_tc), .co(hi_co), .ovf(hi_ovf));

    sync_up_counter_chk #(.WIDTH(4), .MODULUS(10)) chk_a (
        .clk(clk), .rst_n(a_rst_n), .ci(a_ci), .q(a_q), .tc(a_tc), .co(a_co));

    sync_up_counter_chk #(.WIDTH(4), .MODULUS(16)) chk_b (
        .clk(clk), .rst_n(b_rst_n), .ci(b_ci), .q(b_q), .tc(b_tc), .co(b_co));

    typedef struct {
        bit rst_n;
        bit clr;
        bit load;
        bit ci;
        int din;
        int q;
        bit tc;
        bit ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(bit r, bit c, bit l, bit i, int d, int eq, bit et, bit eo);
        vec_t v;
        v.rst_n = r; v.clr = c; v.load = l; v.ci = i;
        v.din = d; v.q = eq; v.tc = et; v.ovf = eo;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: count modulo modn, flag whenever the count returns to zero by counting
    task automatic model_step(input int modn, input bit rst_n, input bit clr, input bit load,
                              input bit ci, input int din, inout int mq, inout int movf);
        if (!rst_n || clr) begin
            mq = 0;
            movf = 0;
        end else if (load) begin
            mq = (din < modn) ? din : 0;
        end else if (ci) begin
            mq = (mq + 1) % modn;
            if (mq == 0) movf = 1;
        end
    endtask

    initial begin
        int qa, oa, qb, ob;

        a_rst_n = 1'b0; a_ci = 1'b0; a_load = 1'b0; a_clr = 1'b0; a_din = 4'd0;
        b_rst_n = 1'b0; b_ci = 1'b0; b_load = 1'b0; b_clr = 1'b0; b_din = 4'd0;
        c_rst_n = 1'b0; c_ci = 1'b0;

        // rst, clr, load, ci, din -> q, tc, ovf (modulo 10)
        vecs.push_back(mkv(0, 0, 0, 1,  0, 0, 0, 0));
        vecs.push_back(mkv(0, 0, 0, 1,  0, 0, 0, 0));
        vecs.push_back(mkv(1, 0, 0, 1,  0, 1, 0, 0));
        vecs.push_back(mkv(1, 0, 1, 0,  7, 7, 0, 0));
        vecs.push_back(mkv(1, 0, 0, 1,  0, 8, 0, 0));
        vecs.push_back(mkv(1, 0, 0, 1,  0, 9, 1, 0));
        vecs.push_back(mkv(1, 0, 0, 1,  0, 0, 0, 1));
        vecs.push_back(mkv(1, 0, 1, 0, 12, 0, 0, 1));
        vecs.push_back(mkv(1, 0, 1, 1,  5, 5, 0, 1));
        vecs.push_back(mkv(1, 1, 1, 1,  3, 0, 0, 0));
        vecs.push_back(mkv(1, 0, 1, 0,  9, 9, 1, 0));
        vecs.push_back(mkv(1, 0, 0, 0,  0, 9, 1, 0));
        vecs.push_back(mkv(1, 0, 0, 1,  0, 0, 0, 1));
        vecs.push_back(mkv(1, 0, 1, 0, 15, 0, 0, 1));
        vecs.push_back(mkv(1, 1, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mkv(1, 0, 1, 0,  6, 6, 0, 0));
        vecs.push_back(mkv(0, 0, 0, 1,  0, 0, 0, 0));
        for (int i = 0; i < 5; i++) vecs.push_back(mkv(1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(1, 0, 0, 1,  0, 1, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            a_rst_n = vecs[i].rst_n;
            a_clr   = vecs[i].clr;
            a_load  = vecs[i].load;
            a_ci    = vecs[i].ci;
            a_din   = 4'(vecs[i].din);
            tick();
            chk($sformatf("vec%0d q", i),   int'(a_q),   vecs[i].q);
            chk($sformatf("vec%0d tc", i),  int'(a_tc),  int'(vecs[i].tc));
            chk($sformatf("vec%0d co", i),  int'(a_co),  int'(vecs[i].ci & vecs[i].tc));
            chk($sformatf("vec%0d ovf", i), int'(a_ovf), int'(vecs[i].ovf));
        end

        // Modulo-16 full count from reset through one wrap
        b_rst_n = 1'b0; b_ci = 1'b1;
        tick(); tick();
        chk("m16 reset q", int'(b_q), 0);
        chk("m16 reset co", int'(b_co), 0);
        chk("m16 reset ovf", int'(b_ovf), 0);
        b_rst_n = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            #1;
            chk($sformatf("m16 step%0d q", k),   int'(b_q),   k % 16);
            chk($sformatf("m16 step%0d tc", k),  int'(b_tc),  int'((k % 16) == 15));
            chk($sformatf("m16 step%0d co", k),  int'(b_co),  int'((k % 16) == 15));
            chk($sformatf("m16 step%0d ovf", k), int'(b_ovf), int'(k == 16));
            tick();
        end
        chk("m16 after wrap q", int'(b_q), 1);
        chk("m16 ovf sticky", int'(b_ovf), 1);

        // Two-digit decimal cascade 00..99
        c_rst_n = 1'b0; c_ci = 1'b0;
        tick(); tick();
        c_rst_n = 1'b1; c_ci = 1'b1;
        for (int n = 0; n < 100; n++) begin
            #1;
            chk($sformatf("casc %0d value", n), int'(hi_q) * 10 + int'(lo_q), n);
            chk($sformatf("casc %0d hi co", n), int'(hi_co), int'(n == 99));
            tick();
        end
        chk("casc wrap value", int'(hi_q) * 10 + int'(lo_q), 0);
        chk("casc hi ovf", int'(hi_ovf), 1);
        c_ci = 1'b0;

        // Randomized traffic on both counters against the reference model
        qa = 0; oa = 0; qb = 0; ob = 0;
        for (int t = 0; t < 600; t++) begin
            a_rst_n = (t == 0) ? 1'b0 : ($urandom_range(0, 49) != 0);
            a_clr   = ($urandom_range(0, 29) == 0);
            a_load  = ($urandom_range(0, 9) == 0);
            a_ci    = ($urandom_range(0, 2) != 0);
            a_din   = 4'($urandom_range(0, 15));
            b_rst_n = (t == 0) ? 1'b0 : ($urandom_range(0, 49) != 0);
            b_clr   = ($urandom_range(0, 29) == 0);
            b_load  = ($urandom_range(0, 9) == 0);
            b_ci    = ($urandom_range(0, 2) != 0);
            b_din   = 4'($urandom_range(0, 15));
            model_step(10, a_rst_n, a_clr, a_load, a_ci, int'(a_din), qa, oa);
            model_step(16, b_rst_n, b_clr, b_load, b_ci, int'(b_din), qb, ob);
            tick();
            chk($sformatf("rnd%0d a q", t),   int'(a_q),   qa);
            chk($sformatf("rnd%0d a tc", t),  int'(a_tc),  int'(qa == 9));
            chk($sformatf("rnd%0d a co", t),  int'(a_co),  int'(a_ci && qa == 9));
            chk($sformatf("rnd%0d a ovf", t), int'(a_ovf), oa);
            chk($sformatf("rnd%0d b q", t),   int'(b_q),   qb);
            chk($sformatf("rnd%0d b tc", t),  int'(b_tc),  int'(qb == 15));
            chk($sformatf("rnd%0d b co", t),  int'(b_co),  int'(b_ci && qb == 15));
            chk($sformatf("rnd%0d b ovf", t), int'(b_ovf), ob);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
